// File: rtl/avl_arbiter.sv
// -----------------------------------------------------------------------------
// avl_arbiter
// Two-master round-robin arbiter in front of one shared Avalon-MM slave.
// The granted master is muxed combinationally onto the slave port, so a
// request raised in IDLE reaches the slave one cycle later.
//
// Parameters:
//   AW - address width
//   DW - data width (byteenable width is DW/8)
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   m0_* / m1_*                     master ports (address, read, write,
//                                   writedata, byteenable, lock in;
//                                   readdata, waitrequest out)
//   s_*                             shared slave port (address, read, write,
//                                   writedata, byteenable out; readdata,
//                                   waitrequest in)
//
// Optional feature (macro AVL_ARB_LOCK_EN): a master that completes a
// transfer with its lock input high keeps the grant for its next transfer.
// Without the macro the lock inputs are ignored.
// -----------------------------------------------------------------------------
module avl_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DW-1:0]     m0_writedata,
    input  logic [DW/8-1:0]   m0_byteenable,
    input  logic              m0_lock,
    output logic [DW-1:0]     m0_readdata,
    output logic              m0_waitrequest,
    input  logic [AW-1:0]     m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DW-1:0]     m1_writedata,
    input  logic [DW/8-1:0]   m1_byteenable,
    input  logic              m1_lock,
    output logic [DW-1:0]     m1_readdata,
    output logic              m1_waitrequest,
    output logic [AW-1:0]     s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DW-1:0]     s_writedata,
    output logic [DW/8-1:0]   s_byteenable,
    input  logic [DW-1:0]     s_readdata,
    input  logic              s_waitrequest
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state_r;
    state_t next_state_s;
    logic   last_grant_r;
    logic   next_last_grant_s;
    logic   req0_s;
    logic   req1_s;
    logic   hold0_s;
    logic   hold1_s;

    assign req0_s = m0_read | m0_write;
    assign req1_s = m1_read | m1_write;

`ifdef AVL_ARB_LOCK_EN
    assign hold0_s = m0_lock;
    assign hold1_s = m1_lock;
`else
    // Lock inputs are deliberately unused in this build.
    logic lock_unused_s;
    assign lock_unused_s = m0_lock ^ m1_lock;
    assign hold0_s       = 1'b0;
    assign hold1_s       = 1'b0;
`endif

    // Read data is broadcast; only the granted master's completion cycle uses it.
    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

    // State and last-grant registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;   // makes m0 win the first tie
        end else begin
            state_r      <= next_state_s;
            last_grant_r <= next_last_grant_s;
        end
    end

    // Next-state arbitration: round-robin on ties, hand-over without bubble.
    always_comb begin
        next_state_s      = state_r;
        next_last_grant_s = last_grant_r;
        case (state_r)
            IDLE: begin
                if (req0_s && req1_s) begin
                    if (last_grant_r) begin
                        next_state_s = GRANT0;
                    end else begin
                        next_state_s = GRANT1;
                    end
                end else if (req0_s) begin
                    next_state_s = GRANT0;
                end else if (req1_s) begin
                    next_state_s = GRANT1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GRANT0: begin
                if (!req0_s) begin
                    next_state_s = IDLE;       // abandoned before completion
                end else if (s_waitrequest) begin
                    next_state_s = GRANT0;     // slave stalling: hold
                end else begin
                    next_last_grant_s = 1'b0;  // completion cycle
                    if (hold0_s) begin
                        next_state_s = GRANT0;
                    end else if (req1_s) begin
                        next_state_s = GRANT1;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
            end
            GRANT1: begin
                if (!req1_s) begin
                    next_state_s = IDLE;
                end else if (s_waitrequest) begin
                    next_state_s = GRANT1;
                end else begin
                    next_last_grant_s = 1'b1;
                    if (hold1_s) begin
                        next_state_s = GRANT1;
                    end else if (req0_s) begin
                        next_state_s = GRANT0;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
            end
            default: begin
                next_state_s      = IDLE;
                next_last_grant_s = 1'b1;
            end
        endcase
    end

    // Slave-side mux and master waitrequests, decoded from the current grant.
    always_comb begin
        s_address      = {AW{1'b0}};
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = {DW{1'b0}};
        s_byteenable   = {(DW/8){1'b0}};
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state_r)
            GRANT0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
            end
            GRANT1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
            end
            default: begin
                s_read  = 1'b0;
                s_write = 1'b0;
            end
        endcase
    end

endmodule
